// File: rtl/seg7_pkg.sv
// Shared constants for the factorisation-game display: game state encodings,
// glyph codes, the prime map shown for player input, and the message tables.
package seg7_pkg;

  typedef logic [3:0] game_state_t;

  localparam game_state_t ST_READY    = 4'h2;
  localparam game_state_t ST_QUESTION = 4'h3;
  localparam game_state_t ST_INPUT    = 4'h4;
  localparam game_state_t ST_DRAW     = 4'h6;
  localparam game_state_t ST_WRONG    = 4'h7;
  localparam game_state_t ST_GOOD     = 4'h8;
  localparam game_state_t ST_OUCH     = 4'h9;
  localparam game_state_t ST_WIN      = 4'hA;
  localparam game_state_t ST_LOSE     = 4'hB;

  // Decimal digits occupy codes 0..9 so a BCD nibble maps straight onto a glyph.
  typedef enum logic [4:0] {
    G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
    G_A, G_LB, G_C, G_LD, G_E, G_G, G_H, G_L, G_LO, G_LR,
    G_S, G_U, G_Y, G_DASH, G_BLANK
  } glyph_t;

  // Message tables are indexed by digit position; entry 0 is the rightmost digit.
  typedef glyph_t msg_t [4];

  localparam msg_t MSG_READY = '{G_Y,     G_LD, G_E,  G_LR};
  localparam msg_t MSG_WRONG = '{G_BLANK, G_LR, G_LR, G_E };
  localparam msg_t MSG_GOOD  = '{G_LD,    G_LO, G_LO, G_G };
  localparam msg_t MSG_OUCH  = '{G_H,     G_C,  G_U,  G_0 };
  localparam msg_t MSG_WIN   = '{G_BLANK, G_S,  G_E,  G_Y };
  localparam msg_t MSG_LOSE  = '{G_E,     G_S,  G_0,  G_L };
  localparam msg_t MSG_DRAW  = '{G_DASH,  G_DASH, G_DASH, G_DASH};

  localparam glyph_t PRIME_MAP [16] = '{
    G_DASH, G_2, G_3, G_5, G_7, G_1, G_3, G_7,
    G_9, G_3, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK
  };

  function automatic glyph_t msg_glyph(game_state_t st, logic [1:0] pos);
    glyph_t g;
    case (st)
      ST_READY: g = MSG_READY[pos];
      ST_WRONG: g = MSG_WRONG[pos];
      ST_GOOD:  g = MSG_GOOD[pos];
      ST_OUCH:  g = MSG_OUCH[pos];
      ST_WIN:   g = MSG_WIN[pos];
      ST_LOSE:  g = MSG_LOSE[pos];
      ST_DRAW:  g = MSG_DRAW[pos];
      default:  g = G_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic is_blink_state(game_state_t st);
    return st inside {ST_WRONG, ST_OUCH, ST_WIN, ST_LOSE};
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Game-controller to display-driver bundle: game inputs one way, board-pin
// segment/digit lines and the frame pulse the other.
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  game_state_t             state;
  logic [3:0]              din;
  logic [4*NUM_DIGITS-1:0] que;
  logic [6:0]              n_hex;
  logic [NUM_DIGITS-1:0]   n_dig;
  logic                    frame;

  modport master (output state, din, que, input n_hex, n_dig, frame);
  modport slave  (input state, din, que, output n_hex, n_dig, frame);
endinterface

// File: rtl/seg7_glyph_rom.sv
// Glyph code to active-low segment pattern {g,f,e,d,c,b,a}.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] seg_n
);

  always_comb begin
    case (glyph)
      G_0:     seg_n = 7'h40;
      G_1:     seg_n = 7'h79;
      G_2:     seg_n = 7'h24;
      G_3:     seg_n = 7'h30;
      G_4:     seg_n = 7'h19;
      G_5:     seg_n = 7'h12;
      G_6:     seg_n = 7'h02;
      G_7:     seg_n = 7'h58;
      G_8:     seg_n = 7'h00;
      G_9:     seg_n = 7'h10;
      G_A:     seg_n = 7'h08;
      G_LB:    seg_n = 7'h03;
      G_C:     seg_n = 7'h46;
      G_LD:    seg_n = 7'h21;
      G_E:     seg_n = 7'h06;
      G_G:     seg_n = 7'h42;
      G_H:     seg_n = 7'h09;
      G_L:     seg_n = 7'h47;
      G_LO:    seg_n = 7'h23;
      G_LR:    seg_n = 7'h2F;
      G_S:     seg_n = 7'h12;
      G_U:     seg_n = 7'h41;
      G_Y:     seg_n = 7'h11;
      G_DASH:  seg_n = 7'h3F;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode display driver: scan prescaler, digit
// index, frame-based blink, state-change tracking and registered pin outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input logic            clk,
  input logic            rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PRESC_W-1:0] presc;
  logic [DIG_W-1:0]   idx;
  logic [BLINK_W-1:0] bcnt;
  logic               blink_on;
  logic               wrap_q;
  game_state_t        state_q;

  logic   last_tick, last_digit, wrap, state_chg, visible, upper_zero;
  int     idx_i;
  logic [3:0] nib;
  glyph_t glyph;
  logic [6:0] seg_n;

  assign idx_i      = int'(idx);
  assign last_tick  = (presc == PRESC_W'(SCAN_DIV - 1));
  assign last_digit = (idx == DIG_W'(NUM_DIGITS - 1));
  assign wrap       = last_tick && last_digit;
  assign state_chg  = (bus.state != state_q);
  // A fresh state shows immediately even if the stored phase is still off.
  assign visible    = !is_blink_state(bus.state) || blink_on || state_chg;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path latches.
    upper_zero = 1'b1;
    glyph      = G_BLANK;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= idx_i && bus.que[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    nib = bus.que[4*idx_i +: 4];
    case (bus.state)
      ST_QUESTION:
        if (nib <= 4'd9 && !(idx_i != 0 && upper_zero)) glyph = glyph_t'({1'b0, nib});
      ST_INPUT:
        if (idx_i == 0) glyph = PRIME_MAP[bus.din];
      ST_READY, ST_WRONG, ST_GOOD, ST_OUCH, ST_WIN, ST_LOSE, ST_DRAW:
        if (idx_i < 4) glyph = msg_glyph(bus.state, idx_i[1:0]);
      default: ;
    endcase
  end

  seg7_glyph_rom u_glyph_rom (
    .glyph (glyph),
    .seg_n (seg_n)
  );

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      bcnt      <= '0;
      blink_on  <= 1'b1;
      wrap_q    <= 1'b0;
      state_q   <= '0;
      bus.n_hex <= 7'h7F;
      bus.n_dig <= '1;
      bus.frame <= 1'b0;
    end else begin
      presc <= last_tick ? '0 : presc + 1'b1;
      if (last_tick) idx <= last_digit ? '0 : idx + 1'b1;

      // Outputs lag the index by one cycle, so the frame pulse needs one extra stage.
      wrap_q    <= wrap;
      bus.frame <= wrap_q;

      state_q <= bus.state;
      if (state_chg) begin
        bcnt     <= '0;
        blink_on <= 1'b1;
      end else if (wrap) begin
        if (bcnt == BLINK_W'(BLINK_DIV - 1)) begin
          bcnt     <= '0;
          blink_on <= ~blink_on;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end

      bus.n_dig <= ~(NUM_DIGITS'(1) << idx);
      bus.n_hex <= visible ? seg_n : 7'h7F;
    end
  end

endmodule
